axi_sram_slave: RTL and testbench

- AXI3 slave/responder for the uncached data and instruction bus masters: 32-bit data, 4-bit ID, 4-bit LEN.
- Serves one read or one write burst at a time from a word-addressed synchronous SRAM port.
- Intended as on-chip scratch RAM and as the bench-side memory model for the bus masters.
- Handles FIXED/INCR bursts of 1-16 beats, with SLVERR/DECERR checking.

---
 rtl/axi_slv_pkg.sv | 47 ++++
 rtl/axi_slv_arb.sv | 51 +++++
 rtl/axi_sram_slave.sv | 188 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI3 SRAM slave.
package axi_slv_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_R_MEM,
        ST_R_BEAT,
        ST_W_BEAT,
        ST_W_RESP
    } state_e;

    // Latched request attributes held for the whole burst.
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
        logic [1:0]       burst;
        logic [1:0]       err;
    } req_t;

    // Response code for a new burst: range error dominates format errors.
    function automatic logic [1:0] req_err(input logic       out_of_range,
                                           input logic [2:0] size,
                                           input logic [1:0] burst);
        if (out_of_range) begin
            return RESP_DECERR;
        end
        if ((size != SIZE_WORD) || burst[1]) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_slv_arb.sv
// Two-requester AR/AW arbiter. Optional macro: AXI_SLV_RR_ARB_EN selects
// round-robin (last-served loses a conflict); otherwise write always wins.
module axi_slv_arb (
    input  logic clk,
    input  logic rst,
    input  logic rd_req,
    input  logic wr_req,
    input  logic accept,
    output logic grant_rd,
    output logic grant_wr
);

`ifdef AXI_SLV_RR_ARB_EN
    logic last_rd_q;
    logic last_rd_d;

    // Remember which channel was served last; reset as "read served".
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_rd_q <= 1'b1;
        end else begin
            last_rd_q <= last_rd_d;
        end
    end

    assign last_rd_d = accept ? grant_rd : last_rd_q;

    // On conflict the channel not served last wins.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (rd_req && wr_req) begin
            grant_wr = last_rd_q;
            grant_rd = !last_rd_q;
        end else begin
            grant_rd = rd_req;
            grant_wr = wr_req;
        end
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clk, rst, accept};

    // Fixed priority: a pending write beats a pending read.
    always_comb begin
        grant_wr = wr_req;
        grant_rd = rd_req && !wr_req;
    end
`endif

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one FIXED/INCR burst at a time from a synchronous SRAM.
// Optional macro: AXI_SLV_RR_ARB_EN (round-robin AR/AW arbitration).
module axi_sram_slave
    import axi_slv_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        axis_arid,
    input  logic [31:0]       axis_araddr,
    input  logic [3:0]        axis_arlen,
    input  logic [2:0]        axis_arsize,
    input  logic [1:0]        axis_arburst,
    input  logic              axis_arvalid,
    output logic              axis_arready,
    input  logic [3:0]        axis_awid,
    input  logic [31:0]       axis_awaddr,
    input  logic [3:0]        axis_awlen,
    input  logic [2:0]        axis_awsize,
    input  logic [1:0]        axis_awburst,
    input  logic              axis_awvalid,
    output logic              axis_awready,
    output logic [3:0]        axis_rid,
    output logic [31:0]       axis_rdata,
    output logic [1:0]        axis_rresp,
    output logic              axis_rlast,
    output logic              axis_rvalid,
    input  logic              axis_rready,
    input  logic [31:0]       axis_wdata,
    input  logic [3:0]        axis_wstrb,
    input  logic              axis_wlast,
    input  logic              axis_wvalid,
    output logic              axis_wready,
    output logic [3:0]        axis_bid,
    output logic [1:0]        axis_bresp,
    output logic              axis_bvalid,
    input  logic              axis_bready,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    logic              grant_rd, grant_wr, accept_c;
    logic              last_beat_c, ar_oor_c, aw_oor_c, wlast_bad_c;
    logic [ADDR_W-1:0] addr_next_c;
    logic              unused_addr;

    assign unused_addr = ^{axis_araddr[1:0], axis_awaddr[1:0]};

    assign ar_oor_c    = |axis_araddr[31:ADDR_W+2];
    assign aw_oor_c    = |axis_awaddr[31:ADDR_W+2];
    assign last_beat_c = (cnt_q == req_q.len);
    assign wlast_bad_c = (axis_wlast != last_beat_c);
    assign addr_next_c = (req_q.burst == BURST_INCR) ? addr_q + ADDR_W'(1) : addr_q;
    assign accept_c    = rst && (state_q == ST_IDLE) &&
                         ((axis_awvalid && grant_wr) || (axis_arvalid && grant_rd));

    axi_slv_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (axis_arvalid),
        .wr_req   (axis_awvalid),
        .accept   (accept_c),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    // State and burst-context registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and channel/memory outputs decoded from the current state.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        axis_arready = 1'b0;
        axis_awready = 1'b0;
        axis_rid     = '0;
        axis_rdata   = '0;
        axis_rresp   = RESP_OKAY;
        axis_rlast   = 1'b0;
        axis_rvalid  = 1'b0;
        axis_wready  = 1'b0;
        axis_bid     = '0;
        axis_bresp   = RESP_OKAY;
        axis_bvalid  = 1'b0;
        mem_en       = 1'b0;
        mem_wen      = '0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                axis_awready = rst && grant_wr;
                axis_arready = rst && grant_rd;
                if (axis_awvalid && axis_awready) begin
                    req_d   = '{id: axis_awid, len: axis_awlen, burst: axis_awburst,
                                err: req_err(aw_oor_c, axis_awsize, axis_awburst)};
                    addr_d  = axis_awaddr[ADDR_W+1:2];
                    cnt_d   = '0;
                    state_d = ST_W_BEAT;
                end else if (axis_arvalid && axis_arready) begin
                    req_d   = '{id: axis_arid, len: axis_arlen, burst: axis_arburst,
                                err: req_err(ar_oor_c, axis_arsize, axis_arburst)};
                    addr_d  = axis_araddr[ADDR_W+1:2];
                    cnt_d   = '0;
                    state_d = ST_R_MEM;
                end
            end
            ST_R_MEM: begin
                if (req_q.err == RESP_OKAY) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q;
                end
                state_d = ST_R_BEAT;
            end
            ST_R_BEAT: begin
                axis_rvalid = 1'b1;
                axis_rid    = req_q.id;
                axis_rresp  = req_q.err;
                axis_rlast  = last_beat_c;
                axis_rdata  = (req_q.err == RESP_OKAY) ? mem_rdata : '0;
                if (axis_rready) begin
                    if (last_beat_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + LEN_W'(1);
                        addr_d  = addr_next_c;
                        state_d = ST_R_MEM;
                    end
                end
            end
            ST_W_BEAT: begin
                axis_wready = 1'b1;
                if (axis_wvalid) begin
                    if (wlast_bad_c && (req_q.err != RESP_DECERR)) begin
                        req_d.err = RESP_SLVERR;
                    end
                    if ((req_d.err == RESP_OKAY) && (|axis_wstrb)) begin
                        mem_en    = 1'b1;
                        mem_wen   = axis_wstrb;
                        mem_addr  = addr_q;
                        mem_wdata = axis_wdata;
                    end
                    if (last_beat_c) begin
                        state_d = ST_W_RESP;
                    end else begin
                        cnt_d  = cnt_q + LEN_W'(1);
                        addr_d = addr_next_c;
                    end
                end
            end
            ST_W_RESP: begin
                axis_bvalid = 1'b1;
                axis_bid    = req_q.id;
                axis_bresp  = req_q.err;
                if (axis_bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave with a behavioural synchronous SRAM.
module tb_axi_sram_slave;

    localparam int unsigned ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        axis_arid = '0, axis_awid = '0;
    logic [31:0]       axis_araddr = '0, axis_awaddr = '0;
    logic [3:0]        axis_arlen = '0, axis_awlen = '0;
    logic [2:0]        axis_arsize = '0, axis_awsize = '0;
    logic [1:0]        axis_arburst = '0, axis_awburst = '0;
    logic              axis_arvalid = 1'b0, axis_awvalid = 1'b0;
    logic              axis_arready, axis_awready;
    logic [3:0]        axis_rid;
    logic [31:0]       axis_rdata;
    logic [1:0]        axis_rresp;
    logic              axis_rlast, axis_rvalid;
    logic              axis_rready = 1'b1;
    logic [31:0]       axis_wdata = '0;
    logic [3:0]        axis_wstrb = '0;
    logic              axis_wlast = 1'b0, axis_wvalid = 1'b0;
    logic              axis_wready;
    logic [3:0]        axis_bid;
    logic [1:0]        axis_bresp;
    logic              axis_bvalid;
    logic              axis_bready = 1'b1;
    logic              mem_en;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;

    logic [31:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};

    int n_cmp = 0;
    int n_bad = 0;
    int mem_acc = 0;
    int rr_mode = 0;

    logic [38:0] rq[$];
    logic [5:0]  bq[$];
    logic [49:0] wq[$];

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];

    logic        hold_q = 1'b0;
    logic [38:0] held = '0;
    logic        lat_arm = 1'b0;
    int          lat_cnt = 0;

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .axis_arid(axis_arid), .axis_araddr(axis_araddr), .axis_arlen(axis_arlen),
        .axis_arsize(axis_arsize), .axis_arburst(axis_arburst),
        .axis_arvalid(axis_arvalid), .axis_arready(axis_arready),
        .axis_awid(axis_awid), .axis_awaddr(axis_awaddr), .axis_awlen(axis_awlen),
        .axis_awsize(axis_awsize), .axis_awburst(axis_awburst),
        .axis_awvalid(axis_awvalid), .axis_awready(axis_awready),
        .axis_rid(axis_rid), .axis_rdata(axis_rdata), .axis_rresp(axis_rresp),
        .axis_rlast(axis_rlast), .axis_rvalid(axis_rvalid), .axis_rready(axis_rready),
        .axis_wdata(axis_wdata), .axis_wstrb(axis_wstrb), .axis_wlast(axis_wlast),
        .axis_wvalid(axis_wvalid), .axis_wready(axis_wready),
        .axis_bid(axis_bid), .axis_bresp(axis_bresp), .axis_bvalid(axis_bvalid),
        .axis_bready(axis_bready),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous SRAM: read data appears after the strobe and holds until the next one.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen == 4'b0000) begin
                mem_rdata <= mem[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wen[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] rs, input logic l);
        rq.push_back({id, d, rs, l});
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] rs);
        bq.push_back({id, rs});
    endtask

    task automatic push_w(input logic [13:0] a, input logic [3:0] we, input logic [31:0] d);
        wq.push_back({a, we, d});
    endtask

    // Monitor: pops expectations whenever the DUT presents an R/B beat or a memory write.
    always @(negedge clk) begin
        if (!rst) begin
            hold_q  = 1'b0;
            lat_arm = 1'b0;
        end else begin
            if (hold_q) check("r_hold", {axis_rvalid, axis_rid, axis_rdata, axis_rresp, axis_rlast}, {1'b1, held});
            hold_q = axis_rvalid && !axis_rready;
            held   = {axis_rid, axis_rdata, axis_rresp, axis_rlast};
            if (axis_rvalid && axis_rready) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else check("r_beat", {axis_rid, axis_rdata, axis_rresp, axis_rlast}, rq.pop_front());
            end
            if (lat_arm) begin
                lat_cnt++;
                if (axis_rvalid) begin
                    check("r_latency", lat_cnt, 2);
                    lat_arm = 1'b0;
                end
            end
            if (axis_arvalid && axis_arready) begin
                lat_arm = 1'b1;
                lat_cnt = 0;
            end
            if (axis_bvalid && axis_bready) begin
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else check("b_resp", {axis_bid, axis_bresp}, bq.pop_front());
            end
            if (mem_en) begin
                mem_acc++;
                if (mem_wen != 4'b0000) begin
                    if (wq.size() == 0) check("memw_unexpected", {mem_addr, mem_wen, mem_wdata}, 0);
                    else check("mem_write", {mem_addr, mem_wen, mem_wdata}, wq.pop_front());
                end
            end
        end
    end

    // rready pattern: 0 = always ready, 1 = toggling, 2 = never ready.
    initial forever begin
        @(posedge clk);
        #1;
        case (rr_mode)
            1:       axis_rready = ~axis_rready;
            2:       axis_rready = 1'b0;
            default: axis_rready = 1'b1;
        endcase
    end

    task automatic ar_req(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
        int n;
        axis_arid = id; axis_araddr = a; axis_arlen = len;
        axis_arsize = sz; axis_arburst = bu; axis_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axis_arready && n < 60);
        if (!axis_arready) check("arready_timeout", 0, 1);
        @(posedge clk); #1;
        axis_arvalid = 1'b0;
    endtask

    task automatic aw_w(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                        input logic [2:0] sz, input logic [1:0] bu);
        int n;
        axis_awid = id; axis_awaddr = a; axis_awlen = len;
        axis_awsize = sz; axis_awburst = bu; axis_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axis_awready && n < 60);
        if (!axis_awready) check("awready_timeout", 0, 1);
        @(posedge clk); #1;
        axis_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axis_wvalid = 1'b1; axis_wdata = wd[i]; axis_wstrb = ws[i]; axis_wlast = wl[i];
            n = 0;
            do begin @(negedge clk); n++; end while (!axis_wready && n < 60);
            if (!axis_wready) check("wready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        axis_wvalid = 1'b0;
        axis_wlast  = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        do begin @(negedge clk); #1; n++; end
        while ((rq.size() != 0 || bq.size() != 0 || wq.size() != 0) && n < 300);
        if (n >= 300) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ctrl"}, {axis_arready, axis_awready, axis_rvalid, axis_rlast, axis_rresp, axis_rid,
                              axis_wready, axis_bvalid, axis_bid, axis_bresp, mem_en, mem_wen, mem_addr}, 0);
        check({nm, "_data"}, {axis_rdata, mem_wdata}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int m0;
        logic exp_wr2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // INCR write of 4 beats to words 4..7
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; wl[i] = (i == 3);
            push_w(14'(4 + i), 4'hF, 32'hA0 + 32'(i));
        end
        push_b(4'd5, 2'b00);
        aw_w(4'd5, 32'h10, 4'd3, 3'b010, 2'b01);
        settle();

        // INCR read back with rready toggling
        rr_mode = 1;
        for (int i = 0; i < 4; i++) push_r(4'd2, 32'hA0 + 32'(i), 2'b00, (i == 3));
        ar_req(4'd2, 32'h10, 4'd3, 3'b010, 2'b01);
        settle();
        rr_mode = 0;

        // FIXED write: both beats land on word 8
        wd[0] = 32'h11; ws[0] = 4'hF; wl[0] = 1'b0;
        wd[1] = 32'h22; ws[1] = 4'hF; wl[1] = 1'b1;
        push_w(14'd8, 4'hF, 32'h11); push_w(14'd8, 4'hF, 32'h22); push_b(4'd1, 2'b00);
        aw_w(4'd1, 32'h20, 4'd1, 3'b010, 2'b00);
        settle();

        // Partial strobe merge, then a zero-strobe beat that must not write
        wd[0] = 32'h5555FFFF; ws[0] = 4'b0011; wl[0] = 1'b1;
        push_w(14'd8, 4'b0011, 32'h5555FFFF); push_b(4'd3, 2'b00);
        aw_w(4'd3, 32'h20, 4'd0, 3'b010, 2'b01);
        settle();
        wd[0] = 32'hDEADBEEF; ws[0] = 4'b0000; wl[0] = 1'b1;
        push_b(4'd4, 2'b00);
        aw_w(4'd4, 32'h20, 4'd0, 3'b010, 2'b01);
        settle();
        push_r(4'd6, 32'h0000FFFF, 2'b00, 1'b0); push_r(4'd6, 32'h0000FFFF, 2'b00, 1'b1);
        ar_req(4'd6, 32'h20, 4'd1, 3'b010, 2'b00);
        settle();

        // INCR wrap at top of the window
        wd[0] = 32'hC0; ws[0] = 4'hF; wl[0] = 1'b0;
        wd[1] = 32'hC1; ws[1] = 4'hF; wl[1] = 1'b1;
        push_w(14'h3FFF, 4'hF, 32'hC0); push_w(14'h0000, 4'hF, 32'hC1); push_b(4'd7, 2'b00);
        aw_w(4'd7, 32'hFFFC, 4'd1, 3'b010, 2'b01);
        settle();
        push_r(4'd8, 32'hC0, 2'b00, 1'b0); push_r(4'd8, 32'hC1, 2'b00, 1'b1);
        ar_req(4'd8, 32'hFFFC, 4'd1, 3'b010, 2'b01);
        settle();

        // DECERR read: zero data, no memory access
        m0 = mem_acc;
        push_r(4'd3, 32'h0, 2'b11, 1'b0); push_r(4'd3, 32'h0, 2'b11, 1'b1);
        ar_req(4'd3, 32'h0001_0000, 4'd1, 3'b010, 2'b01);
        settle();
        check("decerr_rd_noaccess", 64'(mem_acc - m0), 0);

        // SLVERR write on bad size: no write
        m0 = mem_acc;
        wd[0] = 32'h12345678; ws[0] = 4'hF; wl[0] = 1'b1;
        push_b(4'd4, 2'b10);
        aw_w(4'd4, 32'h30, 4'd0, 3'b001, 2'b01);
        settle();
        check("slverr_wr_noaccess", 64'(mem_acc - m0), 0);

        // Early wlast on len-2 write: only the first beat is stored
        wd[0] = 32'hD0; ws[0] = 4'hF; wl[0] = 1'b0;
        wd[1] = 32'hD1; ws[1] = 4'hF; wl[1] = 1'b1;
        wd[2] = 32'hD2; ws[2] = 4'hF; wl[2] = 1'b0;
        push_w(14'd16, 4'hF, 32'hD0); push_b(4'd5, 2'b10);
        aw_w(4'd5, 32'h40, 4'd2, 3'b010, 2'b01);
        settle();
        push_r(4'd6, 32'hD0, 2'b00, 1'b0); push_r(4'd6, 32'h0, 2'b00, 1'b0); push_r(4'd6, 32'h0, 2'b00, 1'b1);
        ar_req(4'd6, 32'h40, 4'd2, 3'b010, 2'b01);
        settle();

        // First AR/AW conflict: write wins in both arbitration modes
        wd[0] = 32'h66; ws[0] = 4'hF; wl[0] = 1'b1;
        push_w(14'd20, 4'hF, 32'h66); push_b(4'd6, 2'b00); push_r(4'd7, 32'hA0, 2'b00, 1'b1);
        fork
            aw_w(4'd6, 32'h50, 4'd0, 3'b010, 2'b01);
            ar_req(4'd7, 32'h10, 4'd0, 3'b010, 2'b01);
            begin
                @(negedge clk);
                check("arb1_awready", axis_awready, 1);
                check("arb1_arready", axis_arready, 0);
            end
        join
        settle();

        // A lone write makes write the last-served channel
        wd[0] = 32'h77; ws[0] = 4'hF; wl[0] = 1'b1;
        push_w(14'd21, 4'hF, 32'h77); push_b(4'd1, 2'b00);
        aw_w(4'd1, 32'h54, 4'd0, 3'b010, 2'b01);
        settle();

        // Second conflict: round-robin now favours the read
`ifdef AXI_SLV_RR_ARB_EN
        exp_wr2 = 1'b0;
`else
        exp_wr2 = 1'b1;
`endif
        wd[0] = 32'h88; ws[0] = 4'hF; wl[0] = 1'b1;
        push_w(14'd22, 4'hF, 32'h88); push_b(4'd2, 2'b00); push_r(4'd3, 32'h66, 2'b00, 1'b1);
        fork
            aw_w(4'd2, 32'h58, 4'd0, 3'b010, 2'b01);
            ar_req(4'd3, 32'h50, 4'd0, 3'b010, 2'b01);
            begin
                @(negedge clk);
                check("arb2_awready", axis_awready, 64'(exp_wr2));
                check("arb2_arready", axis_arready, 64'(!exp_wr2));
            end
        join
        settle();

        // Reset during R_BEAT of a len-7 read drops the burst
        rr_mode = 2;
        axis_rready = 1'b0;
        ar_req(4'd8, 32'h10, 4'd7, 3'b010, 2'b01);
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!axis_rvalid && n < 20);
            check("rst_test_rvalid_seen", axis_rvalid, 1);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midburst_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        rr_mode = 0;
        axis_rready = 1'b1;
        push_r(4'd9, 32'hA0, 2'b00, 1'b1);
        ar_req(4'd9, 32'h10, 4'd0, 3'b010, 2'b01);
        settle();

        check("rq_empty", 64'(rq.size()), 0);
        check("bq_empty", 64'(bq.size()), 0);
        check("wq_empty", 64'(wq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
